shift_cmd_queue: RTL and testbench
==================================

Name: shift_cmd_queue

Overview:
- Command queue and result register placed around the 16-bit shift/rotate ALU.
- Accepts {choice, operand, shift amount} commands over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Presents the head entry to the combinational ALU and registers the ALU result into a valid/ready output stage.
- Decouples the command producer from the result consumer, sustaining one operation per cycle.

Parameters:
- DEPTH, 4, number of FIFO command entries; power of two, minimum 2.
- CNT_W, 3, width of count; equals clog2(DEPTH+1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO and output stage.
- in_valid  input  1  command present.
- in_ready  output  1  queue can accept a command.
- in_choice  input  2  00 SLL, 01 RL, 10 SRL, 11 RR.
- in_data  input  16  operand.
- in_shift  input  4  shift/rotate amount, 0..15.
- alu_choice  output  2  head entry choice, to ALU choice.
- alu_i0  output  16  head entry operand, to ALU i0.
- alu_shift_by  output  4  head entry amount, to ALU shift_by.
- alu_o  input  16  ALU result (combinational from alu_* outputs).
- out_valid  output  1  result held in output register.
- out_ready  input  1  consumer takes result.
- out_data  output  16  registered ALU result.
- out_choice  output  2  choice of the operation that produced out_data.
- count  output  CNT_W  FIFO occupancy; excludes the output register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - write pointer, read pointer and count = 0.
  - out_valid = 0, out_data = 0x0000, out_choice = 00.
  - in_ready forced 0 while rst_n is low.
  - FIFO storage contents are don't-care.
- in_ready = (count < DEPTH) while out of reset; combinational from count only, with no dependence on the same-cycle pop.
- push = in_valid & in_ready:
  - writes {in_choice, in_data, in_shift} at the write pointer.
  - the write pointer wraps modulo DEPTH.
- alu_* outputs:
  - driven combinationally from the entry at the read pointer when count > 0.
  - all zeros when count == 0.
- pop = (count > 0) & (~out_valid | out_ready). On pop:
  - out_data <= alu_o, out_choice <= head choice, out_valid <= 1.
  - the read pointer advances and wraps modulo DEPTH.
- out_valid & out_ready with no pop: out_valid <= 0; out_data and out_choice hold their values.
- out_valid & ~out_ready: out_data and out_choice stay stable and no pop occurs.
- Count update: count + push - pop. Simultaneous push and pop keeps count unchanged and is legal at any occupancy below DEPTH.
- Full (count == DEPTH): in_ready = 0. A pop in that cycle frees a slot, and in_ready rises on the next cycle.
- Empty: there is no bypass. A command accepted in cycle N reaches the head in N+1, pops at the N+1 edge, and out_valid is seen in cycle N+2. Minimum latency is 2 cycles.
- Throughput is 1 result per cycle with out_ready held high.
- Ordering: results leave in strict acceptance order.
- flush (synchronous, highest priority):
  - pointers and count <= 0, out_valid <= 0.
  - out_data and out_choice hold their values.
  - push and pop in the same cycle are discarded.
- Reset asserted mid-operation: the whole stream is lost and outputs return to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset, then in_valid=1 for one cycle with choice=00, data=0x0001, shift=4, out_ready=1 -> out_valid=1 exactly 2 cycles after accept, out_data=0x0010, out_choice=00, count back to 0.
- Back-to-back commands, then deassert in_valid:
  - Commands: RL 0x8000 by 1, SRL 0x8000 by 15, RR 0x8001 by 1, SLL 0xFFFF by 15.
  - Required: four consecutive out_valid cycles carrying 0x0001, 0x0001, 0xC000, 0x8000 in order.
- Backpressure:
  - Drive out_ready=0 and push 6 commands.
  - Required: the 1st lands in the output register and the next 4 fill the FIFO (count=4, in_ready=0); the 6th is held with no data loss.
  - Then drive out_ready=1. Required: five results drain in order, one per cycle, and the 6th is accepted once in_ready rises.
- Full with simultaneous push/pop:
  - At count=3, out_valid=1, out_ready=1 and in_valid=1 -> count stays 3.
  - At count=4 with a pop -> no push that cycle, and in_ready=1 the next cycle.
- flush asserted with count=3 and out_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
  - Required: no stale results appear afterwards, and a new command RR 0x0003 by 1 yields 0x8001.
- rst_n pulsed low mid-stream (count=2, out_valid=1) -> out_valid, out_data and count go to 0 without a clock edge, in_ready=0 during reset.
  - Required: normal operation resumes after release.

Source files
------------

// File: rtl/shift_cmd_queue_if.sv
// Command, ALU and result signals of the shift command queue, with DUT (slave) and driver (master) views.
interface shift_cmd_queue_if #(
  parameter int CNT_W = 3
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_choice;
  logic [15:0]      in_data;
  logic [3:0]       in_shift;
  logic [1:0]       alu_choice;
  logic [15:0]      alu_i0;
  logic [3:0]       alu_shift_by;
  logic [15:0]      alu_o;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [1:0]       out_choice;
  logic [CNT_W-1:0] count;

  modport slave (
    input  flush, in_valid, in_choice, in_data, in_shift, alu_o, out_ready,
    output in_ready, alu_choice, alu_i0, alu_shift_by, out_valid, out_data, out_choice, count
  );

  modport master (
    output flush, in_valid, in_choice, in_data, in_shift, alu_o, out_ready,
    input  in_ready, alu_choice, alu_i0, alu_shift_by, out_valid, out_data, out_choice, count
  );
endinterface

// File: rtl/shift_cmd_queue.sv
// Command FIFO and registered result stage around a combinational shift/rotate ALU; 2-cycle accept-to-result, no bypass.
// A stalled result (out_ready low) blocks pops; in_ready drops only when the FIFO itself is full.
module shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_cmd_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]  choice;
    logic [15:0] data;
    logic [3:0]  shift;
  } cmd_t;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_vld;
  logic [15:0]      r_out_dat;
  logic [1:0]       r_out_choice;

  logic             w_empty;
  logic             w_in_rdy;
  logic             w_push;
  logic             w_pop;
  cmd_t             w_head;

  assign w_empty  = (r_count == '0);
  assign w_in_rdy = rst_n & (r_count < CNT_W'(DEPTH));
  // flush wins over any same-cycle transfer in either direction
  assign w_push   = bus.in_valid & w_in_rdy & ~bus.flush;
  assign w_pop    = ~w_empty & (~r_out_vld | bus.out_ready) & ~bus.flush;
  assign w_head   = w_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.in_choice, bus.in_data, bus.in_shift};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // out_data/out_choice only move on a pop, so a flush or a drain leaves the last result visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld    <= 1'b0;
      r_out_dat    <= 16'h0000;
      r_out_choice <= 2'b00;
    end else if (bus.flush) begin
      r_out_vld    <= 1'b0;
    end else if (w_pop) begin
      r_out_vld    <= 1'b1;
      r_out_dat    <= bus.alu_o;
      r_out_choice <= w_head.choice;
    end else if (bus.out_ready) begin
      r_out_vld    <= 1'b0;
    end
  end

  assign bus.in_ready     = w_in_rdy;
  assign bus.alu_choice   = w_head.choice;
  assign bus.alu_i0       = w_head.data;
  assign bus.alu_shift_by = w_head.shift;
  assign bus.out_valid    = r_out_vld;
  assign bus.out_data     = r_out_dat;
  assign bus.out_choice   = r_out_choice;
  assign bus.count        = r_count;
endmodule

// File: tb/tb_shift_cmd_queue.sv
// Testbench for shift_cmd_queue: directed vector table, corner-case sequences and random traffic vs a queue model.
module tb_shift_cmd_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int NV    = 10;

  logic clk;
  logic rst_n;

  shift_cmd_queue_if #(.CNT_W(CNT_W)) bus ();

  shift_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU semantics: 00 SLL, 01 rotate left, 10 SRL, 11 rotate right
  function automatic logic [15:0] alu_f(input logic [1:0] c, input logic [15:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = {d, d};
    case (c)
      2'b00:   return d << s;
      2'b01:   begin w = w << s; return w[31:16]; end
      2'b10:   return d >> s;
      default: begin w = w >> s; return w[15:0]; end
    endcase
  endfunction

  assign bus.alu_o = alu_f(bus.alu_choice, bus.alu_i0, bus.alu_shift_by);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: queue of accepted commands plus the result register
  logic [21:0] mq[$];
  logic        m_ov;
  logic [15:0] m_od;
  logic [1:0]  m_oc;

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0;
    m_od = 16'h0000;
    m_oc = 2'b00;
  endtask

  task automatic model_step(input logic v, input logic [1:0] c, input logic [15:0] d,
                            input logic [3:0] s, input logic ordy, input logic fl);
    bit acc;
    bit pop;
    logic [21:0] h;
    acc = v && (mq.size() < DEPTH);
    pop = (mq.size() > 0) && (!m_ov || ordy);
    if (fl) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if (pop) begin
        h = mq.pop_front();
        m_od = alu_f(h[21:20], h[19:4], h[3:0]);
        m_oc = h[21:20];
        m_ov = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (acc) mq.push_back({c, d, s});
    end
  endtask

  task automatic compare_model();
    logic [21:0] h;
    h = (mq.size() > 0) ? mq[0] : 22'h0;
    check("in_ready",     32'(bus.in_ready),     32'(mq.size() < DEPTH));
    check("count",        32'(bus.count),        32'(mq.size()));
    check("out_valid",    32'(bus.out_valid),    32'(m_ov));
    check("out_data",     32'(bus.out_data),     32'(m_od));
    check("out_choice",   32'(bus.out_choice),   32'(m_oc));
    check("alu_choice",   32'(bus.alu_choice),   32'(h[21:20]));
    check("alu_i0",       32'(bus.alu_i0),       32'(h[19:4]));
    check("alu_shift_by", 32'(bus.alu_shift_by), 32'(h[3:0]));
  endtask

  // One clock: called at a falling edge, checks state, drives inputs for the next rising edge
  task automatic cyc(input logic v, input logic [1:0] c, input logic [15:0] d,
                     input logic [3:0] s, input logic ordy, input logic fl);
    compare_model();
    bus.in_valid  = v;
    bus.in_choice = c;
    bus.in_data   = d;
    bus.in_shift  = s;
    bus.out_ready = ordy;
    bus.flush     = fl;
    model_step(v, c, d, s, ordy, fl);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 2'b00, 16'h0000, 4'd0, ordy, 1'b0);
  endtask

  typedef struct {
    logic [1:0]  c;
    logic [15:0] d;
    logic [3:0]  s;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [NV];
  logic [1:0]  bc [6];
  logic [15:0] bd [6];
  logic [3:0]  bs [6];

  initial begin
    tbl[0] = '{2'b01, 16'h8000, 4'd1,  16'h0001};
    tbl[1] = '{2'b10, 16'h8000, 4'd15, 16'h0001};
    tbl[2] = '{2'b11, 16'h8001, 4'd1,  16'hC000};
    tbl[3] = '{2'b00, 16'hFFFF, 4'd15, 16'h8000};
    tbl[4] = '{2'b01, 16'h1234, 4'd4,  16'h2341};
    tbl[5] = '{2'b11, 16'h1234, 4'd4,  16'h4123};
    tbl[6] = '{2'b10, 16'hF000, 4'd12, 16'h000F};
    tbl[7] = '{2'b01, 16'hABCD, 4'd0,  16'hABCD};
    tbl[8] = '{2'b11, 16'h0003, 4'd1,  16'h8001};
    tbl[9] = '{2'b00, 16'hFFFF, 4'd0,  16'hFFFF};
    for (int j = 0; j < 6; j++) begin
      bc[j] = 2'(j);
      bd[j] = 16'(16'h0123 + j * 16'h0101);
      bs[j] = 4'(j + 1);
    end

    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_choice = 2'b00;
    bus.in_data   = 16'h0000;
    bus.in_shift  = 4'd0;
    bus.out_ready = 1'b0;
    model_reset();

    #2;
    check("rst in_ready",   32'(bus.in_ready),   32'd0);
    check("rst out_valid",  32'(bus.out_valid),  32'd0);
    check("rst out_data",   32'(bus.out_data),   32'd0);
    check("rst out_choice", 32'(bus.out_choice), 32'd0);
    check("rst count",      32'(bus.count),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single command: SLL 0x0001 by 4, result two cycles after accept
    cyc(1'b1, 2'b00, 16'h0001, 4'd4, 1'b1, 1'b0);
    check("lat1 out_valid", 32'(bus.out_valid), 32'd0);
    check("lat1 count",     32'(bus.count),     32'd1);
    idle(1'b1);
    check("lat2 out_valid",  32'(bus.out_valid),  32'd1);
    check("lat2 out_data",   32'(bus.out_data),   32'h0010);
    check("lat2 out_choice", 32'(bus.out_choice), 32'd0);
    check("lat2 count",      32'(bus.count),      32'd0);
    idle(1'b1);

    // Vector table streamed back to back: one result per cycle, in order
    for (int k = 0; k <= NV + 1; k++) begin
      if (k < NV) cyc(1'b1, tbl[k].c, tbl[k].d, tbl[k].s, 1'b1, 1'b0);
      else        idle(1'b1);
      if (k >= 1 && k <= NV) begin
        check("vec out_valid",  32'(bus.out_valid),  32'd1);
        check("vec out_data",   32'(bus.out_data),   32'(tbl[k-1].exp));
        check("vec out_choice", 32'(bus.out_choice), 32'(tbl[k-1].c));
      end
    end
    check("vec drained out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: fill output register and FIFO, sixth command held off
    for (int k = 0; k < 6; k++) cyc(1'b1, bc[k], bd[k], bs[k], 1'b0, 1'b0);
    check("bp count",     32'(bus.count),     32'd4);
    check("bp in_ready",  32'(bus.in_ready),  32'd0);
    check("bp out_valid", 32'(bus.out_valid), 32'd1);
    check("bp out_data",  32'(bus.out_data),  32'(alu_f(bc[0], bd[0], bs[0])));
    cyc(1'b1, bc[5], bd[5], bs[5], 1'b1, 1'b0);
    check("full pop count",    32'(bus.count),    32'd3);
    check("full pop in_ready", 32'(bus.in_ready), 32'd1);
    check("bp drain1",         32'(bus.out_data), 32'(alu_f(bc[1], bd[1], bs[1])));
    cyc(1'b1, bc[5], bd[5], bs[5], 1'b1, 1'b0);
    check("push+pop count", 32'(bus.count),    32'd3);
    check("bp drain2",      32'(bus.out_data), 32'(alu_f(bc[2], bd[2], bs[2])));
    for (int k = 3; k < 6; k++) begin
      idle(1'b1);
      check("bp drain out_valid", 32'(bus.out_valid), 32'd1);
      check("bp drain out_data",  32'(bus.out_data),  32'(alu_f(bc[k], bd[k], bs[k])));
    end
    idle(1'b1);
    check("bp end out_valid", 32'(bus.out_valid), 32'd0);

    // Flush with count=3 and a held result
    for (int k = 0; k < 4; k++) cyc(1'b1, bc[k], bd[k], bs[k], 1'b0, 1'b0);
    check("pre-flush count",     32'(bus.count),     32'd3);
    check("pre-flush out_valid", 32'(bus.out_valid), 32'd1);
    cyc(1'b1, 2'b01, 16'h5555, 4'd3, 1'b1, 1'b1);
    check("flush count",     32'(bus.count),     32'd0);
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    check("flush in_ready",  32'(bus.in_ready),  32'd1);
    check("flush hold data", 32'(bus.out_data),  32'(alu_f(bc[0], bd[0], bs[0])));
    for (int k = 0; k < 3; k++) idle(1'b1);
    cyc(1'b1, 2'b11, 16'h0003, 4'd1, 1'b1, 1'b0);
    idle(1'b1);
    check("post-flush out_valid", 32'(bus.out_valid), 32'd1);
    check("post-flush out_data",  32'(bus.out_data),  32'h8001);
    idle(1'b1);

    // Asynchronous reset mid-stream (count=2, result held)
    for (int k = 0; k < 3; k++) cyc(1'b1, bc[k+1], bd[k+1], bs[k+1], 1'b0, 1'b0);
    check("pre-rst count",     32'(bus.count),     32'd2);
    check("pre-rst out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid",  32'(bus.out_valid),  32'd0);
    check("async rst out_data",   32'(bus.out_data),   32'd0);
    check("async rst out_choice", 32'(bus.out_choice), 32'd0);
    check("async rst count",      32'(bus.count),      32'd0);
    check("async rst in_ready",   32'(bus.in_ready),   32'd0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("in-rst in_ready", 32'(bus.in_ready), 32'd0);
      check("in-rst count",    32'(bus.count),    32'd0);
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    model_reset();
    @(negedge clk);

    // Random traffic; out_ready bias changes per block to reach full and empty often
    for (int blk = 0; blk < 8; blk++) begin
      int bias;
      bias = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 2 : 3);
      for (int k = 0; k < 60; k++) begin
        cyc(1'($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)),
            16'($urandom),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) < bias),
            1'($urandom_range(0, 47) == 0));
      end
    end
    for (int k = 0; k < 8; k++) idle(1'b1);
    compare_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
